// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
//   Shares one AHB manager port among NUM_MGR requesting managers.
//   Fixed priority (index 0 highest), ownership held for a whole transaction
//   or across transactions while the owner holds Lock, and per-requester
//   wait counters that let a starved manager jump ahead of the fixed order.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   Req        : per-manager level-sensitive bus request
//   Lock       : per-manager lock, only the current owner's bit is looked at
//   TransDone  : current owner's final data phase completes this cycle
//   Grant      : registered one-hot grant, zero when the bus is unowned
//   GrantValid : OR of Grant
//   GrantIdx   : binary index of the set Grant bit, 0 when unowned
//   Starved    : per-manager flag, high while its wait count equals MAXWAIT
// ---------------------------------------------------------------------------
module ahb_bus_arbiter #(
    parameter int NUM_MGR = 4,
    parameter int MAXWAIT = 3,
    parameter int WCW     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_MGR-1:0]         Req,
    input  logic [NUM_MGR-1:0]         Lock,
    input  logic                       TransDone,
    output logic [NUM_MGR-1:0]         Grant,
    output logic                       GrantValid,
    output logic [$clog2(NUM_MGR)-1:0] GrantIdx,
    output logic [NUM_MGR-1:0]         Starved
);

    localparam int IW = $clog2(NUM_MGR);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_MGR-1:0] grant_reg, grant_next;
    logic [IW-1:0]      idx_reg, idx_next;
    logic [NUM_MGR-1:0] starved_vec;
    logic               arb_event;

    // Selection: starved requesters first, then plain fixed priority.
    logic [NUM_MGR-1:0] starved_req;
    logic [NUM_MGR-1:0] sel_cand;
    logic [NUM_MGR-1:0] sel_onehot;
    logic [IW-1:0]      sel_idx;

    always_comb begin
        starved_req = Req & starved_vec;
        sel_cand    = (|starved_req) ? starved_req : Req;
        // Isolate the lowest set bit (two's complement trick).
        sel_onehot  = sel_cand & (~sel_cand + {{(NUM_MGR-1){1'b0}}, 1'b1});
        sel_idx     = '0;
        for (int i = 0; i < NUM_MGR; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    // Ownership state machine: next-state and next-grant.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        idx_next   = idx_reg;
        arb_event  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|Req) begin
                    arb_event  = 1'b1;
                    grant_next = sel_onehot;
                    idx_next   = sel_idx;
                    state_next = OWNED;
                end
            end
            OWNED: begin
                // The owner's own Req is irrelevant until its transfer ends;
                // a locked owner simply keeps the bus with no arbitration.
                if (TransDone && !Lock[idx_reg]) begin
                    arb_event  = 1'b1;
                    grant_next = sel_onehot;
                    idx_next   = sel_idx;
                    state_next = (|Req) ? OWNED : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            idx_reg   <= idx_next;
        end
    end

    // Per-requester wait counters. The starved flag is registered from the
    // counter's next value so it always matches the stored count.
    generate
        for (genvar gi = 0; gi < NUM_MGR; gi++) begin : g_wait
            logic [WCW-1:0] cnt_reg, cnt_next;
            logic           starved_reg;

            always_comb begin
                cnt_next = cnt_reg;
                if (!Req[gi]) begin
                    cnt_next = '0;
                end else if (arb_event) begin
                    if (grant_next[gi]) begin
                        cnt_next = '0;
                    end else if (cnt_reg != WCW'(MAXWAIT)) begin
                        cnt_next = cnt_reg + WCW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg     <= '0;
                    starved_reg <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    starved_reg <= (cnt_next == WCW'(MAXWAIT));
                end
            end

            assign starved_vec[gi] = starved_reg;
        end
    endgenerate

    assign Grant      = grant_reg;
    assign GrantValid = |grant_reg;
    assign GrantIdx   = idx_reg;
    assign Starved    = starved_vec;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_bus_arbiter
//   Directed vectors push hand-computed expectations into a scoreboard queue;
//   a monitor pops one entry per cycle on the falling edge and compares.
//   A short random phase checks grant shape and the starvation bound.
// ---------------------------------------------------------------------------
module tb_ahb_bus_arbiter;

    localparam int NUM_MGR = 4;
    localparam int MAXWAIT = 3;
    localparam int WCW     = 4;

    logic                 clk;
    logic                 reset;
    logic [NUM_MGR-1:0]   Req;
    logic [NUM_MGR-1:0]   Lock;
    logic                 TransDone;
    logic [NUM_MGR-1:0]   Grant;
    logic                 GrantValid;
    logic [1:0]           GrantIdx;
    logic [NUM_MGR-1:0]   Starved;

    ahb_bus_arbiter #(
        .NUM_MGR(NUM_MGR),
        .MAXWAIT(MAXWAIT),
        .WCW    (WCW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .Lock      (Lock),
        .TransDone (TransDone),
        .Grant     (Grant),
        .GrantValid(GrantValid),
        .GrantIdx  (GrantIdx),
        .Starved   (Starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] grant;
        logic [1:0] idx;
        logic [3:0] starved;
    } exp_t;

    exp_t sb[$];
    int   total_checks = 0;
    int   pass_checks  = 0;
    int   step_id      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            pass_checks++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("txn %0d: Grant=%b Idx=%0d Valid=%0b Starved=%b (exp Grant=%b Idx=%0d Starved=%b)",
                     e.id, Grant, GrantIdx, GrantValid, Starved, e.grant, e.idx, e.starved);
            check($sformatf("grant[%0d]", e.id),   32'(Grant),      32'(e.grant));
            check($sformatf("idx[%0d]", e.id),     32'(GrantIdx),   32'(e.idx));
            check($sformatf("valid[%0d]", e.id),   32'(GrantValid), 32'(|e.grant));
            check($sformatf("starved[%0d]", e.id), 32'(Starved),    32'(e.starved));
        end
    end

    // Called at posedge+1: drive one cycle of inputs, then queue the result
    // expected after the next rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic td,
                        input logic [3:0] eg, input logic [1:0] ei, input logic [3:0] es);
        exp_t e;
        Req       = r;
        Lock      = l;
        TransDone = td;
        @(posedge clk);
        step_id++;
        e.id      = step_id;
        e.grant   = eg;
        e.idx     = ei;
        e.starved = es;
        sb.push_back(e);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    int          waits [NUM_MGR];
    logic        ev;
    logic [3:0]  gv;
    logic [1:0]  idx_from_grant;

    initial begin
        reset     = 1'b1;
        Req       = '0;
        Lock      = '0;
        TransDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant",   32'(Grant),      32'd0);
        check("reset_valid",   32'(GrantValid), 32'd0);
        check("reset_idx",     32'(GrantIdx),   32'd0);
        check("reset_starved", 32'(Starved),    32'd0);
        reset = 1'b0;

        //    Req      Lock     TD    Grant    Idx   Starved
        // Fixed priority, zero-dead-cycle handover
        step(4'b1010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000);
        step(4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // Lock hold by owner 2, then release
        step(4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000);
        step(4'b0111, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0000);
        step(4'b0111, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0000);
        step(4'b0111, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0000);
        step(4'b0111, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // Starvation of manager 3 behind manager 0
        step(4'b1001, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000);
        step(4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000);
        step(4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b1000);
        step(4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // Release to idle: owner drops Req early, grant held until TransDone
        step(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000);
        step(4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // Non-owner Lock ignored; manager 1 starves and escalates
        step(4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000);
        step(4'b0011, 4'b0010, 1'b1, 4'b0001, 2'd0, 4'b0000);
        step(4'b0011, 4'b0010, 1'b1, 4'b0001, 2'd0, 4'b0010);
        step(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 4'b0000);
        step(4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000);
        // Take ownership as manager 2, then reset mid-transaction
        step(4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000);
        drain();
        Req = 4'b0100;
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_grant",   32'(Grant),      32'd0);
        check("async_reset_valid",   32'(GrantValid), 32'd0);
        check("async_reset_starved", 32'(Starved),    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000);
        drain();

        // Random phase: grant shape and bounded waiting.
        for (int i = 0; i < NUM_MGR; i++) waits[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            gv = Grant;
            idx_from_grant = 2'd0;
            for (int i = 0; i < NUM_MGR; i++) if (gv[i]) idx_from_grant = 2'(i);
            check("rand_onehot", 32'(((gv & (gv - 4'd1)) == 4'd0)), 32'd1);
            check("rand_idx",    32'(GrantIdx),   32'(idx_from_grant));
            check("rand_valid",  32'(GrantValid), 32'(|gv));
            if ($urandom_range(0, 7) == 0) Req = 4'($urandom_range(0, 15));
            Lock      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            TransDone = 1'($urandom_range(0, 1));
            ev = ((gv == 4'b0000) && (Req != 4'b0000)) ||
                 ((gv != 4'b0000) && TransDone && !Lock[GrantIdx]);
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_MGR; i++) begin
                if (!Req[i])        waits[i] = 0;
                else if (ev) begin
                    if (Grant[i])   waits[i] = 0;
                    else            waits[i] = waits[i] + 1;
                end
            end
            if (ev) begin
                for (int i = 0; i < NUM_MGR; i++)
                    check($sformatf("rand_wait_bound[%0d]", i),
                          32'(waits[i] <= MAXWAIT + NUM_MGR), 32'd1);
            end
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
